// File: rtl/riscv_enc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_enc_pkg
//  Description : Opcode constants, field bundle and range helper for the
//                RV32I instruction encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_enc_pkg;

    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [3:0]  func;
        logic [31:0] imm;
    } enc_fields_t;

    // True when imm[31:msb] are all equal, i.e. the value fits as signed.
    function automatic logic imm_fits(input logic [31:0] imm, input int unsigned msb);
        logic [31:0] w_hi;
        w_hi = 32'($signed(imm) >>> msb);
        return (w_hi == '0) || (w_hi == '1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_encoder_if
//  Description : Field-input / encoded-word-output handshake bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface instruction_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              restart;
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        in_opcode;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [3:0]        in_func;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;
    logic [7:0]        err_count;

    modport slave (
        input  restart, in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_func, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_err, err_count
    );

    modport master (
        output restart, in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_func, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_err, err_count
    );
endinterface
`default_nettype wire

// File: rtl/instr_field_pack.sv
`default_nettype none
// ============================================================================
//  Module      : instr_field_pack
//  Description : Combinational packing of decoder-convention fields into an
//                RV32I word plus an immediate-range / opcode error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_field_pack
    import riscv_enc_pkg::*;
(
    input  enc_fields_t i_fields,
    output logic [31:0] o_instr,
    output logic        o_err
);

    logic [2:0] w_f3;
    assign w_f3 = i_fields.func[3:1];

    always_comb begin
        o_instr = NOP_INSTR;
        o_err   = 1'b0;
        case (i_fields.opcode)
            OP_R: begin
                o_instr = {1'b0, i_fields.func[0], 5'b0, i_fields.rs2, i_fields.rs1,
                           w_f3, i_fields.rd, i_fields.opcode};
            end
            OP_LOAD, OP_IMM: begin
                o_instr = {i_fields.imm[11:0], i_fields.rs1, w_f3, i_fields.rd, i_fields.opcode};
                // Shift-right immediates carry the arithmetic/logical select in bit 30.
                if (w_f3 == 3'b101) o_instr[30] = i_fields.func[0];
                o_err = !imm_fits(i_fields.imm, 11);
            end
            OP_STORE: begin
                o_instr = {i_fields.imm[11:5], i_fields.rs2, i_fields.rs1, w_f3,
                           i_fields.imm[4:0], i_fields.opcode};
                o_err = !imm_fits(i_fields.imm, 11);
            end
            OP_BRANCH: begin
                // Branch imm is in half-word units, so bit 0 of the byte offset is implicit.
                o_instr = {i_fields.imm[11], i_fields.imm[9:4], i_fields.rs2, i_fields.rs1,
                           w_f3, i_fields.imm[3:0], i_fields.imm[10], i_fields.opcode};
                o_err = !imm_fits(i_fields.imm, 11);
            end
            OP_LUI, OP_AUIPC: begin
                o_instr = {i_fields.imm[19:0], i_fields.rd, i_fields.opcode};
                o_err = !imm_fits(i_fields.imm, 19);
            end
            OP_JAL: begin
                o_instr = {i_fields.imm[20], i_fields.imm[10:1], i_fields.imm[11],
                           i_fields.imm[19:12], i_fields.rd, i_fields.opcode};
                o_err = !imm_fits(i_fields.imm, 20) || i_fields.imm[0];
            end
            default: begin
                o_instr = NOP_INSTR;
                o_err   = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instruction_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_encoder
//  Description : Registers one encoded RV32I word per handshake, tagged with a
//                wrapping instruction-memory address and an error counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_encoder
    import riscv_enc_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    instruction_encoder_if.slave   bus
);

    localparam logic [ADDR_W-1:0] c_base_addr = ADDR_W'(BASE_ADDR);
    localparam logic [7:0]        c_err_max   = 8'hFF;

    enc_fields_t       w_fields;
    logic [31:0]       w_pack_instr;
    logic              w_pack_err;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_out_hs;

    logic              r_valid;
    logic [31:0]       r_instr;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_err_count;

    assign w_fields = '{opcode: bus.in_opcode, rd: bus.in_rd, rs1: bus.in_rs1,
                        rs2: bus.in_rs2, func: bus.in_func, imm: bus.in_imm};

    instr_field_pack u_pack (
        .i_fields (w_fields),
        .o_instr  (w_pack_instr),
        .o_err    (w_pack_err)
    );

    // restart masks both sides so it wins over any handshake on the same edge.
    assign w_in_ready = (!r_valid || bus.out_ready) && !bus.restart;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_out_hs   = r_valid && bus.out_ready && !bus.restart;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_instr     <= '0;
            r_err       <= 1'b0;
            r_addr      <= c_base_addr;
            r_err_count <= '0;
        end else if (bus.restart) begin
            r_valid <= 1'b0;
            r_addr  <= c_base_addr;
        end else begin
            if (w_out_hs) begin
                r_addr <= r_addr + ADDR_W'(1);
                if (r_err && (r_err_count != c_err_max)) r_err_count <= r_err_count + 8'd1;
            end
            if (w_accept) begin
                r_valid <= 1'b1;
                r_instr <= w_pack_instr;
                r_err   <= w_pack_err;
            end else if (w_out_hs) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_valid;
    assign bus.out_instr = r_instr;
    assign bus.out_addr  = r_addr;
    assign bus.out_err   = r_err;
    assign bus.err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_instruction_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_encoder
//  Description : Directed + random bench for two encoder instances (8-bit and
//                2-bit address) against a field-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_encoder;

    localparam int unsigned BASE_B = 2;
    localparam logic [6:0] T_R = 7'h33, T_LOAD = 7'h03, T_IMM = 7'h13, T_STORE = 7'h23;
    localparam logic [6:0] T_BRANCH = 7'h63, T_JAL = 7'h6F, T_LUI = 7'h37, T_AUIPC = 7'h17;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [3:0]  fn;
        logic [31:0] imm;
    } fld_t;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        fld_t        f;
    } exp_t;

    typedef struct packed {
        logic [4:0]  rd, rs1, rs2;
        logic [3:0]  fn;
        logic [31:0] imm;
    } sig_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instruction_encoder_if #(.ADDR_W(8)) if_a ();
    instruction_encoder_if #(.ADDR_W(2)) if_b ();

    instruction_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    instruction_encoder #(.ADDR_W(2), .BASE_ADDR(BASE_B)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

    assign if_b.restart   = if_a.restart;
    assign if_b.in_valid  = if_a.in_valid;
    assign if_b.in_opcode = if_a.in_opcode;
    assign if_b.in_rd     = if_a.in_rd;
    assign if_b.in_rs1    = if_a.in_rs1;
    assign if_b.in_rs2    = if_a.in_rs2;
    assign if_b.in_func   = if_a.in_func;
    assign if_b.in_imm    = if_a.in_imm;
    assign if_b.out_ready = if_a.out_ready;

    int          checks = 0;
    int          failures = 0;
    exp_t        q[$];
    int unsigned addr_a = 0;
    int unsigned addr_b = BASE_B;
    int unsigned cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic fld_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [3:0] fn, input logic [31:0] imm);
        fld_t f;
        f.op = op; f.rd = rd; f.rs1 = rs1; f.rs2 = rs2; f.fn = fn; f.imm = imm;
        return f;
    endfunction

    // Reference encoder: builds the word arithmetically from architectural offsets.
    function automatic exp_t model(input fld_t f);
        exp_t        e;
        logic [31:0] w, off, base;
        int          s;
        s     = $signed(f.imm);
        base  = 32'(f.op) | (32'(f.fn[3:1]) << 12) | (32'(f.rs1) << 15);
        e.f   = f;
        e.err = 1'b0;
        case (f.op)
            T_R: w = base | (32'(f.rd) << 7) | (32'(f.rs2) << 20) | (32'(f.fn[0]) << 30);
            T_LOAD, T_IMM: begin
                w = base | (32'(f.rd) << 7) | ((f.imm & 32'hFFF) << 20);
                if (f.fn[3:1] == 3'd5) w = (w & ~32'h4000_0000) | (32'(f.fn[0]) << 30);
                e.err = (s < -2048) || (s > 2047);
            end
            T_STORE: begin
                w = base | ((f.imm & 32'h1F) << 7) | (32'(f.rs2) << 20) | (((f.imm >> 5) & 32'h7F) << 25);
                e.err = (s < -2048) || (s > 2047);
            end
            T_BRANCH: begin
                off = f.imm << 1;
                w = base | (((off >> 11) & 32'd1) << 7) | (((off >> 1) & 32'hF) << 8) | (32'(f.rs2) << 20)
                    | (((off >> 5) & 32'h3F) << 25) | (((off >> 12) & 32'd1) << 31);
                e.err = (s < -2048) || (s > 2047);
            end
            T_LUI, T_AUIPC: begin
                w = 32'(f.op) | (32'(f.rd) << 7) | ((f.imm & 32'hFFFFF) << 12);
                e.err = (s < -(1 << 19)) || (s > (1 << 19) - 1);
            end
            T_JAL: begin
                off = f.imm;
                w = 32'(f.op) | (32'(f.rd) << 7) | (((off >> 12) & 32'hFF) << 12) | (((off >> 11) & 32'd1) << 20)
                    | (((off >> 1) & 32'h3FF) << 21) | (((off >> 20) & 32'd1) << 31);
                e.err = (s < -(1 << 20)) || (s > (1 << 20) - 1) || f.imm[0];
            end
            default: begin
                w = 32'h0000_0013;
                e.err = 1'b1;
            end
        endcase
        e.instr = w;
        return e;
    endfunction

    function automatic sig_t exp_sig(input fld_t f);
        sig_t s = '0;
        case (f.op)
            T_R: begin s.rd = f.rd; s.rs1 = f.rs1; s.rs2 = f.rs2; s.fn = f.fn; end
            T_LOAD, T_IMM: begin
                s.rd = f.rd; s.rs1 = f.rs1; s.fn = {f.fn[3:1], 1'b0}; s.imm = f.imm;
                if (f.fn[3:1] == 3'd5) s.imm[10] = f.fn[0];
            end
            T_STORE, T_BRANCH: begin s.rs1 = f.rs1; s.rs2 = f.rs2; s.fn = {f.fn[3:1], 1'b0}; s.imm = f.imm; end
            default: begin s.rd = f.rd; s.imm = f.imm; end
        endcase
        return s;
    endfunction

    // Decoder-side view of a word, used for the round-trip comparison.
    function automatic sig_t dec_sig(input logic [31:0] w);
        sig_t s = '0;
        case (w[6:0])
            T_R: begin s.rd = w[11:7]; s.rs1 = w[19:15]; s.rs2 = w[24:20]; s.fn = {w[14:12], w[30]}; end
            T_LOAD, T_IMM: begin
                s.rd = w[11:7]; s.rs1 = w[19:15]; s.fn = {w[14:12], 1'b0}; s.imm = {{20{w[31]}}, w[31:20]};
            end
            T_STORE: begin
                s.rs1 = w[19:15]; s.rs2 = w[24:20]; s.fn = {w[14:12], 1'b0};
                s.imm = {{20{w[31]}}, w[31:25], w[11:7]};
            end
            T_BRANCH: begin
                s.rs1 = w[19:15]; s.rs2 = w[24:20]; s.fn = {w[14:12], 1'b0};
                s.imm = {{20{w[31]}}, w[31], w[7], w[30:25], w[11:8]};
            end
            T_LUI, T_AUIPC: begin s.rd = w[11:7]; s.imm = {{12{w[31]}}, w[31:12]}; end
            default: begin s.rd = w[11:7]; s.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0}; end
        endcase
        return s;
    endfunction

    function automatic fld_t rnd_fields();
        fld_t f;
        case ($urandom_range(0, 8))
            0: f.op = T_R;      1: f.op = T_LOAD;   2: f.op = T_IMM;   3: f.op = T_STORE;
            4: f.op = T_BRANCH; 5: f.op = T_JAL;    6: f.op = T_LUI;   7: f.op = T_AUIPC;
            default: f.op = 7'($urandom);
        endcase
        f.rd = 5'($urandom); f.rs1 = 5'($urandom); f.rs2 = 5'($urandom); f.fn = 4'($urandom);
        if ($urandom_range(0, 3) == 0) f.imm = $urandom;
        else if (f.op == T_LUI || f.op == T_AUIPC) f.imm = 32'($urandom_range(0, 32'hFFFFF)) - 32'h80000;
        else if (f.op == T_JAL) f.imm = (32'($urandom_range(0, 32'hFFFFF)) - 32'h80000) << 1;
        else f.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        return f;
    endfunction

    // One clock: drive at negedge, check at negedge+1, advance the model at posedge.
    task automatic cycle(input logic v, input fld_t f, input logic ordy, input logic rs, input logic rr);
        logic exp_ready;
        exp_t e;
        @(negedge clk);
        rst = rr;
        if_a.restart = rs; if_a.in_valid = v; if_a.out_ready = ordy;
        if_a.in_opcode = f.op; if_a.in_rd = f.rd; if_a.in_rs1 = f.rs1;
        if_a.in_rs2 = f.rs2; if_a.in_func = f.fn; if_a.in_imm = f.imm;
        if (rr) begin q.delete(); addr_a = 0; addr_b = BASE_B; cnt = 0; end
        #1;
        exp_ready = (q.size() == 0 || ordy) && !rs;
        chk("in_ready", 64'(if_a.in_ready), 64'(exp_ready));
        chk("out_valid", 64'(if_a.out_valid), 64'(q.size() != 0));
        chk("out_addr_a", 64'(if_a.out_addr), 64'(addr_a));
        chk("out_addr_b", 64'(if_b.out_addr), 64'(addr_b));
        chk("err_count", 64'(if_a.err_count), 64'(cnt));
        if (q.size() != 0) begin
            chk("out_instr", 64'(if_a.out_instr), 64'(q[0].instr));
            chk("out_instr_b", 64'(if_b.out_instr), 64'(q[0].instr));
            chk("out_err", 64'(if_a.out_err), 64'(q[0].err));
            if (ordy && !rs && !rr && !q[0].err)
                chk("roundtrip", 64'(dec_sig(if_a.out_instr)), 64'(exp_sig(q[0].f)));
        end
        @(posedge clk);
        if (!rr) begin
            if (rs) begin
                q.delete(); addr_a = 0; addr_b = BASE_B;
            end else begin
                if (q.size() != 0 && ordy) begin
                    e = q.pop_front();
                    if (e.err && cnt < 255) cnt++;
                    addr_a = (addr_a + 1) % 256;
                    addr_b = (addr_b + 1) % 4;
                end
                if (v && exp_ready) q.push_back(model(f));
            end
        end
    endtask

    initial begin
        fld_t f, f2;
        rst = 1'b1;
        if_a.restart = 1'b0; if_a.in_valid = 1'b0; if_a.out_ready = 1'b1;
        if_a.in_opcode = '0; if_a.in_rd = '0; if_a.in_rs1 = '0;
        if_a.in_rs2 = '0; if_a.in_func = '0; if_a.in_imm = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(if_a.out_valid), 64'd0);
        chk("rst_instr", 64'(if_a.out_instr), 64'd0);
        chk("rst_err", 64'(if_a.out_err), 64'd0);
        chk("rst_addr_a", 64'(if_a.out_addr), 64'd0);
        chk("rst_addr_b", 64'(if_b.out_addr), 64'(BASE_B));
        chk("rst_err_count", 64'(if_a.err_count), 64'd0);

        // Directed encodings with known words.
        f = mk(T_R, 5'd3, 5'd1, 5'd2, 4'b0000, 32'd0);
        cycle(1'b1, f, 1'b1, 1'b0, 1'b0); #1;
        chk("add_word", 64'(if_a.out_instr), 64'h002081B3);
        chk("add_addr", 64'(if_a.out_addr), 64'd0);
        f.fn = 4'b0001;
        cycle(1'b1, f, 1'b1, 1'b0, 1'b0); #1;
        chk("sub_word", 64'(if_a.out_instr), 64'h402081B3);
        chk("sub_addr", 64'(if_a.out_addr), 64'd1);
        f = mk(T_IMM, 5'd1, 5'd0, 5'd0, 4'b0000, 32'hFFFF_FFFF);
        cycle(1'b1, f, 1'b1, 1'b0, 1'b0); #1;
        chk("addi_neg_word", 64'(if_a.out_instr), 64'hFFF00093);
        chk("addi_neg_err", 64'(if_a.out_err), 64'd0);
        f.imm = 32'h800;
        cycle(1'b1, f, 1'b1, 1'b0, 1'b0); #1;
        chk("addi_800_word", 64'(if_a.out_instr), 64'h80000093);
        chk("addi_800_err", 64'(if_a.out_err), 64'd1);
        f = mk(T_JAL, 5'd1, 5'd0, 5'd0, 4'b0000, 32'd8);
        cycle(1'b1, f, 1'b1, 1'b0, 1'b0); #1;
        chk("jal_word", 64'(if_a.out_instr), 64'h008000EF);
        chk("err_count_one", 64'(if_a.err_count), 64'd1);
        f.imm = 32'd9;
        cycle(1'b1, f, 1'b1, 1'b0, 1'b0); #1;
        chk("jal_odd_err", 64'(if_a.out_err), 64'd1);
        cycle(1'b0, f, 1'b1, 1'b0, 1'b0);

        // Backpressure: two words offered while the consumer stalls.
        f  = mk(T_STORE, 5'd0, 5'd5, 5'd6, 4'b0100, 32'hFFFF_FFF0);
        f2 = mk(T_BRANCH, 5'd0, 5'd7, 5'd8, 4'b0010, 32'd100);
        cycle(1'b1, f, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, f2, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, f2, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, f2, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, f2, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, f2, 1'b1, 1'b0, 1'b0);

        // restart drops a held word and reloads the base address.
        cycle(1'b1, rnd_fields(), 1'b1, 1'b0, 1'b0);
        cycle(1'b1, f, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, f2, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, f2, 1'b1, 1'b0, 1'b0); #1;
        chk("restart_addr_a", 64'(if_a.out_addr), 64'd0);
        chk("restart_addr_b", 64'(if_b.out_addr), 64'(BASE_B));
        chk("restart_word", 64'(if_a.out_instr), 64'(model(f2).instr));

        // Streaming past the 2-bit address wrap.
        for (int i = 0; i < 6; i++) cycle(1'b1, rnd_fields(), 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, rnd_fields(), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 19) == 0, 1'b0);

        // Asynchronous reset in the middle of a stream.
        cycle(1'b1, rnd_fields(), 1'b1, 1'b0, 1'b0);
        cycle(1'b1, rnd_fields(), 1'b0, 1'b0, 1'b1); #1;
        chk("midrst_instr", 64'(if_a.out_instr), 64'd0);
        chk("midrst_err", 64'(if_a.out_err), 64'd0);
        cycle(1'b0, f, 1'b1, 1'b0, 1'b0);

        // err_count saturation with a run of illegal opcodes.
        f = mk(7'h7F, 5'd1, 5'd2, 5'd3, 4'b0000, 32'd0);
        for (int i = 0; i < 262; i++) cycle(1'b1, f, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, f, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, f, 1'b1, 1'b0, 1'b0); #1;
        chk("err_count_sat", 64'(if_a.err_count), 64'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
